// File: rtl/neo_pkg.sv
// Shared types for the sample-memory arbiter.
//   owner_t     : requester id (0 = host/loader, 1 = NEO engine)
//   arb_state_t : arbiter lock state
//   rd_tag_t    : read-return tag carried alongside the Memory read latency
package neo_pkg;

  localparam int unsigned NEO_N = 16;  // default sample word width
  localparam int unsigned NEO_M = 32;  // default memory depth

  typedef logic owner_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/neo_rd_tag_pipe.sv
// Latency-matched shift register of read tags.
// A tag entered on tag_in appears on tag_out DEPTH cycles later; DEPTH = 0
// is a combinational pass-through.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low clear of every stage
//   tag_in    : tag of the read accepted this cycle
//   tag_out   : tag whose Memory data is on mem_rdata this cycle
//   any_valid : at least one read is still in flight inside the pipe
module neo_rd_tag_pipe
  import neo_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_valid
);

  if (DEPTH == 0) begin : g_pass
    always_comb begin
      tag_out   = tag_in;
      any_valid = 1'b0;
    end
  end else begin : g_pipe
    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    always_comb begin
      tag_out   = stage_q[DEPTH-1];
      any_valid = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        any_valid = any_valid | stage_q[i].valid;
      end
    end
  end

endmodule

// File: rtl/neo_mem_arbiter.sv
// Two-requester arbiter in front of the single sample Memory.
// Requester 0 is the host/loader, requester 1 the NEO engine. One access per
// cycle, round-robin on ties, optional burst lock bounded by LOCK_MAX, and
// read returns routed back to the issuing requester after RD_LAT cycles.
//   Clk, reset          : clock (rising edge), async active-low reset
//   reqX/weX/lockX      : request, write(1)/read(0), keep grant next cycle
//   addrX/wdataX        : word address and write data
//   gntX                : combinational grant; access taken when reqX & gntX
//   rvalidX, rdata_out  : read return for requester X, shared data bus
//   mem_*               : straight to Memory read/write ports
//   busy                : a read is in flight or a lock is held
module neo_mem_arbiter
  import neo_pkg::*;
#(
  parameter int unsigned N        = NEO_N,
  parameter int unsigned M        = NEO_M,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic                   lock0,
  input  logic                   lock1,
  input  logic [$clog2(M)-1:0]   addr0,
  input  logic [$clog2(M)-1:0]   addr1,
  input  logic signed [N-1:0]    wdata0,
  input  logic signed [N-1:0]    wdata1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic signed [N-1:0]    rdata_out,
  output logic [$clog2(M)-1:0]   mem_raddr,
  output logic [$clog2(M)-1:0]   mem_waddr,
  output logic signed [N-1:0]    mem_wdata,
  output logic                   mem_we,
  input  logic signed [N-1:0]    mem_rdata,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(M);
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_t          state_q, state_d;
  owner_t              last_gnt_q, last_gnt_d;
  logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic signed [N-1:0] wdata_q, wdata_d;

  owner_t              sel;
  logic                acc;
  logic                sel_req;
  logic                sel_we;
  logic                sel_lock;
  logic [AW-1:0]       sel_addr;
  logic signed [N-1:0] sel_wdata;
  logic                do_wr;
  logic                do_rd;

  rd_tag_t             tag_in;
  rd_tag_t             tag_out;
  logic                pipe_busy;

  // Grant selection and the selected requester's access fields.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      OWN0: gnt0 = 1'b1;
      OWN1: gnt1 = 1'b1;
      default: begin
        if (req0 && req1) begin
          // Tie goes to whoever was not granted last.
          gnt0 = last_gnt_q;
          gnt1 = ~last_gnt_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    sel       = gnt1;
    sel_req   = sel ? req1   : req0;
    sel_we    = sel ? we1    : we0;
    sel_lock  = sel ? lock1  : lock0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    acc       = (gnt0 & req0) | (gnt1 & req1);
    do_wr     = acc & sel_we;
    do_rd     = acc & ~sel_we;
  end

  // Memory port drive; address/data registers keep the last used value.
  always_comb begin
    mem_we    = do_wr;
    mem_waddr = do_wr ? sel_addr  : waddr_q;
    mem_wdata = do_wr ? sel_wdata : wdata_q;
    mem_raddr = do_rd ? sel_addr  : raddr_q;
    waddr_d   = mem_waddr;
    wdata_d   = mem_wdata;
    raddr_d   = mem_raddr;

    tag_in.valid = do_rd;
    tag_in.owner = sel;
  end

  // Lock FSM and round-robin history.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = acc ? sel : last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc && sel_lock) begin
          state_d    = sel ? OWN1 : OWN0;
          lock_cnt_d = '0;
        end
      end
      default: begin
        // In a locked state sel is always the owner, so sel_req/sel_lock
        // describe the owner even when it is not accessing.
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (!sel_req || (acc && !sel_lock) || (lock_cnt_d == CW'(LOCK_MAX))) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  neo_rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_tag_pipe (
    .clk       (Clk),
    .rst_n     (reset),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (pipe_busy)
  );

  always_comb begin
    rvalid0   = tag_out.valid & ~tag_out.owner;
    rvalid1   = tag_out.valid &  tag_out.owner;
    rdata_out = mem_rdata;
    busy      = pipe_busy | (state_q != IDLE);
  end

endmodule

// File: doc/neo_mem_arbiter.md
Name: neo_mem_arbiter

Overview:
- Shares the single sample Memory (one read port, one write port, M x N signed words) between two requesters.
- Requester 0 is the host/loader that fills and drains sample buffers; requester 1 is the NEO engine.
- Round-robin per-cycle arbitration, optional burst lock with a starvation guard, and read-return routing through a latency-matched owner pipeline.
- Sits between the NEO top level and Memory; Memory ports connect straight to the mem_* outputs.

Parameters:
- N, 16, data word width (signed samples)
- M, 32, memory depth; AW = $clog2(M)
- RD_LAT, 1, Memory read latency in cycles (raddr to rdata), >= 0
- LOCK_MAX, 8, maximum consecutive locked cycles before forced release

Ports:
- Clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0, req1  in  1  access request from requester 0 / 1
- we0, we1  in  1  1 = write, 0 = read
- lock0, lock1  in  1  keep grant for the next cycle
- addr0, addr1  in  AW  word address
- wdata0, wdata1  in  N  write data
- gnt0, gnt1  out  1  combinational grant; access accepted when reqX & gntX
- rvalid0, rvalid1  out  1  read data valid for requester 0 / 1
- rdata_out  out  N  read data, shared by both requesters; qualified by rvalidX
- mem_raddr  out  AW  to Memory raddr
- mem_waddr  out  AW  to Memory waddr
- mem_wdata  out  N  to Memory wdata
- mem_we  out  1  Memory write enable
- mem_rdata  in  N  from Memory rdata
- busy  out  1  1 while a read is in flight or a lock is held

Behaviour:
- At most one access per cycle (read or write), for the requester holding gnt.
- FSM states: IDLE (no owner); OWN0 / OWN1 (lock held by 0 / 1).
- IDLE grant rule:
  - One requester requesting: it is granted.
  - Both requesting: grant the one not equal to last_gnt.
  - last_gnt updates on every accepted access; reset value 1, so requester 0 wins the first tie.
- Accepted access with lockX=1 enters OWNX. In OWNX only X is granted, even if idle.
- Leave OWNX to IDLE when either:
  - X makes an access with lockX=0, or X deasserts reqX (grant released the same cycle as the unlocked access); or
  - lock_cnt reaches LOCK_MAX. That cycle's access is still accepted; next cycle is IDLE and the other requester wins any tie.
- lock_cnt:
  - Clears on entering OWNX.
  - Increments each cycle in OWNX.
  - Width $clog2(LOCK_MAX+1).
- Write: mem_we=1, mem_waddr=addrX, mem_wdata=wdataX in the accept cycle. Otherwise mem_we=0.
- mem_waddr, mem_wdata and mem_raddr hold their last values when unused.
- Read: mem_raddr=addrX in the accept cycle, and {valid=1, owner=X} is pushed into an RD_LAT-deep shift register.
- Read return: rvalidX=1 exactly RD_LAT cycles after acceptance, with rdata_out = mem_rdata. For RD_LAT=0, the return is combinational in the same cycle.
- Back-to-back reads from alternating requesters pipeline fully: one return per cycle, in order.
- Read-after-write to the same address in consecutive cycles returns the new value; this relies on Memory write-before-read timing. The arbiter adds no forwarding.
- busy = any valid stage in the read pipe | state != IDLE.
- Reset (asynchronous, active-low) values:
  - state=IDLE, last_gnt=1, lock_cnt=0, read pipe cleared.
  - gnt0=gnt1=0 and mem_we=0 while reset is asserted.
  - rvalid0=rvalid1=0, busy=0, mem addresses/data 0.
- Reset mid-read: in-flight returns are discarded; no rvalid after release.
- Reset mid-lock: the lock is dropped.
- reqX with gntX=0 is not an error; the requester holds its request until granted.

Decomposition:
- Package neo_pkg holds:
  - typedef owner_t (1-bit requester id)
  - typedef arb_state_t enum {IDLE, OWN0, OWN1}
  - struct rd_tag_t {valid, owner}
  - localparams for the default N and M
- One sub-module, neo_rd_tag_pipe: parameterised RD_LAT-deep shift register of rd_tag_t with asynchronous active-low clear; handles RD_LAT=0 as pass-through.

Test Plan:
- Reset, then req1 write addr=3 data=16'sh7FFF, then req1 read addr=3 -> gnt1 both cycles; mem_we=1 with waddr=3 in the first cycle; rvalid1=1 and rdata_out=7FFF one cycle after the read; rvalid0 stays 0.
- req0 and req1 both held for 4 cycles with no lock -> grants alternate 0,1,0,1 starting with 0.
- req1 lock1=1 held with req0=1, LOCK_MAX=8 -> gnt1 held for 9 consecutive accepted cycles, gnt0 granted in the 10th cycle.
- Alternating reads: r0 addr 5, r1 addr 6, r0 addr 7 (memory preloaded 5,6,7 -> -1,2,-3) -> rvalid0/1/0 on consecutive cycles with rdata -1, 2, -3.
- Read accepted, then reset asserted before RD_LAT elapses -> no rvalid after release; busy=0; next tie goes to requester 0.
- RD_LAT=0 build: req0 read addr 31 (value 16'sh8000) -> rvalid0=1 with rdata_out=8000 in the same cycle.
